// File: rtl/pcs_block_sync_rx_if.sv
// Header stream from the rx gearbox plus the lock/slip status returned to it.
// master drives headers and signal detect; slave is the block-sync engine.
interface pcs_block_sync_rx_if #(
    parameter int HEAD_W = 2
);
    logic              signal_ok_i;
    logic              head_v_i;
    logic [HEAD_W-1:0] head_i;
    logic              block_lock_o;
    logic              slip_v_o;

    modport master (
        output signal_ok_i, head_v_i, head_i,
        input  block_lock_o, slip_v_o
    );

    modport slave (
        input  signal_ok_i, head_v_i, head_i,
        output block_lock_o, slip_v_o
    );
endinterface

// File: rtl/pcs_block_sync_rx.sv
// 66b block lock: counts sync headers per window, asserts lock or requests a one-bit gearbox slip.
// Outputs registered (one cycle after the header); no backpressure, idle while head_v_i is low.
module pcs_block_sync_rx #(
    parameter bit IS_40G      = 1'b1,
    parameter int HEAD_W      = 2,
    parameter int SLIP_WAIT_N = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pcs_block_sync_rx_if.slave   rx
);
    localparam int SH_CNT_MAX   = IS_40G ? 1024 : 64;
    localparam int SH_INVLD_MAX = IS_40G ? 65 : 16;
    localparam int CW           = $clog2(SH_CNT_MAX + 1);
    localparam int IW           = $clog2(SH_INVLD_MAX + 1);
    localparam int WW           = $clog2(SLIP_WAIT_N + 1);

    localparam logic [CW-1:0] CNT_MAX_C   = CW'(SH_CNT_MAX);
    localparam logic [IW-1:0] INVLD_MAX_C = IW'(SH_INVLD_MAX);
    localparam logic [WW-1:0] WAIT_LAST_C = WW'(SLIP_WAIT_N - 1);

    typedef enum logic {COUNT, SLIP_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] sh_cnt_q, sh_cnt_d;
    logic [IW-1:0] sh_invld_cnt_q, sh_invld_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          block_lock_q, block_lock_d;
    logic          slip_v_q, slip_v_d;

    logic          sh_valid;
    logic [CW-1:0] cnt_n;
    logic [IW-1:0] invld_n;
    logic          slip_cond;

    assign sh_valid  = (rx.head_i == HEAD_W'(1)) || (rx.head_i == HEAD_W'(2));
    assign cnt_n     = sh_cnt_q + CW'(1);
    assign invld_n   = sh_invld_cnt_q + IW'(!sh_valid);
    // Unlocked links slip on the first bad header; locked links tolerate bad headers up to the window limit.
    assign slip_cond = !sh_valid && (!block_lock_q || (invld_n == INVLD_MAX_C));

    always_comb begin
        state_d        = state_q;
        sh_cnt_d       = sh_cnt_q;
        sh_invld_cnt_d = sh_invld_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        block_lock_d   = block_lock_q;
        slip_v_d       = 1'b0;

        if (!rx.signal_ok_i) begin
            state_d        = COUNT;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
            wait_cnt_d     = '0;
            block_lock_d   = 1'b0;
        end else if (rx.head_v_i) begin
            unique case (state_q)
                COUNT: begin
                    if (slip_cond) begin
                        slip_v_d       = 1'b1;
                        block_lock_d   = 1'b0;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                        wait_cnt_d     = '0;
                        state_d        = SLIP_WAIT;
                    end else if (cnt_n == CNT_MAX_C) begin
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                        if (invld_n == '0) begin
                            block_lock_d = 1'b1;
                        end
                    end else begin
                        sh_cnt_d       = cnt_n;
                        sh_invld_cnt_d = invld_n;
                    end
                end
                SLIP_WAIT: begin
                    // Headers here still straddle the old boundary; discard them whatever they hold.
                    if (wait_cnt_q == WAIT_LAST_C) begin
                        wait_cnt_d     = '0;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                        state_d        = COUNT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                default: state_d = COUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= COUNT;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            wait_cnt_q     <= '0;
            block_lock_q   <= 1'b0;
            slip_v_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_cnt_q       <= sh_cnt_d;
            sh_invld_cnt_q <= sh_invld_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            block_lock_q   <= block_lock_d;
            slip_v_q       <= slip_v_d;
        end
    end

    assign rx.block_lock_o = block_lock_q;
    assign rx.slip_v_o     = slip_v_q;
endmodule

// File: tb/tb_pcs_block_sync_rx.sv
// Bench for pcs_block_sync_rx: one 10G and one 40G instance, per-cycle expected lock/slip scoreboard.
module tb_pcs_block_sync_rx;
    logic clk = 1'b0;
    logic rst10 = 1'b1;
    logic rst40 = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic  lock;
        logic  slip;
        string nm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pcs_block_sync_rx_if #(.HEAD_W(2)) if10 ();
    pcs_block_sync_rx_if #(.HEAD_W(2)) if40 ();

    pcs_block_sync_rx #(.IS_40G(1'b0), .HEAD_W(2), .SLIP_WAIT_N(2)) dut10 (
        .clk   (clk),
        .reset (rst10),
        .rx    (if10.slave)
    );

    pcs_block_sync_rx #(.IS_40G(1'b1), .HEAD_W(2), .SLIP_WAIT_N(2)) dut40 (
        .clk   (clk),
        .reset (rst40),
        .rx    (if40.slave)
    );

    function automatic logic [1:0] vh(input int i);
        return (i % 2 == 1) ? 2'b01 : 2'b10;
    endfunction

    // Drive one cycle of stimulus (called at negedge), queue the expected outputs, compare after the edge.
    task automatic cyc(input bit s40, input logic sok, input logic hv, input logic [1:0] h,
                       input logic el, input logic es, input string nm);
        exp_t e;
        logic gl, gs;
        if (s40) begin
            if40.signal_ok_i = sok; if40.head_v_i = hv; if40.head_i = h;
        end else begin
            if10.signal_ok_i = sok; if10.head_v_i = hv; if10.head_i = h;
        end
        e.lock = el; e.slip = es; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e  = sb.pop_front();
        gl = s40 ? if40.block_lock_o : if10.block_lock_o;
        gs = s40 ? if40.slip_v_o     : if10.slip_v_o;
        total++;
        if (gl !== e.lock) begin
            bad++;
            $display("FAIL %s block_lock got=%b exp=%b t=%0t", e.nm, gl, e.lock, $time);
        end
        total++;
        if (gs !== e.slip) begin
            bad++;
            $display("FAIL %s slip_v got=%b exp=%b t=%0t", e.nm, gs, e.slip, $time);
        end
        if (s40) if40.head_v_i = 1'b0; else if10.head_v_i = 1'b0;
    endtask

    task automatic test_reset();
        if10.signal_ok_i = 1'b0; if10.head_v_i = 1'b0; if10.head_i = 2'b00;
        if40.signal_ok_i = 1'b0; if40.head_v_i = 1'b0; if40.head_i = 2'b00;
        rst10 = 1'b1; rst40 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({if10.block_lock_o, if10.slip_v_o} !== 2'b00) begin
            bad++; $display("FAIL reset10 got=%b exp=00", {if10.block_lock_o, if10.slip_v_o});
        end
        total++;
        if ({if40.block_lock_o, if40.slip_v_o} !== 2'b00) begin
            bad++; $display("FAIL reset40 got=%b exp=00", {if40.block_lock_o, if40.slip_v_o});
        end
        rst10 = 1'b0; rst40 = 1'b0;
        cyc(0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "idle_after_reset");
    endtask

    task automatic test_lock_acquire();
        for (int i = 1; i <= 64; i++) cyc(0, 1'b1, 1'b1, vh(i), i == 64, 1'b0, "acq10");
    endtask

    task automatic test_slip_unlocked();
        cyc(0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "drop_for_slip");
        cyc(0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, "slip_first_bad");
        cyc(0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, "slipwait_ign1");
        cyc(0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, "slipwait_ign2");
        for (int i = 1; i <= 64; i++) cyc(0, 1'b1, 1'b1, vh(i), i == 64, 1'b0, "relock_after_slip");
    endtask

    task automatic test_locked_invalid();
        for (int i = 1; i <= 64; i++)
            cyc(0, 1'b1, 1'b1, (i % 4 == 0 && i <= 60) ? 2'b11 : vh(i), 1'b1, 1'b0, "win_15_bad");
        // 16th bad header lands on the window end: the slip must win.
        for (int i = 1; i <= 64; i++)
            cyc(0, 1'b1, 1'b1, (i % 4 == 0) ? 2'b11 : vh(i), i != 64, i == 64, "win_16_bad");
        cyc(0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, "wait16_1");
        cyc(0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, "wait16_2");
        for (int i = 1; i <= 64; i++) cyc(0, 1'b1, 1'b1, vh(i), i == 64, 1'b0, "relock3");
    endtask

    task automatic test_window_restart_and_gaps();
        for (int i = 1; i <= 64; i++)
            cyc(0, 1'b1, 1'b1, (i == 64) ? 2'b00 : vh(i), 1'b1, 1'b0, "bad_at_64");
        for (int i = 1; i <= 64; i++)
            cyc(0, 1'b1, 1'b1, (i <= 15) ? 2'b11 : vh(i), 1'b1, 1'b0, "restart_15_bad");
        cyc(0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, "drop_for_gaps");
        for (int c = 0; c < 128; c++)
            cyc(0, 1'b1, c % 2 == 1, (c % 2 == 1) ? vh(c) : 2'b00, c == 127, 1'b0, "gapped_lock");
    endtask

    task automatic test_signal_loss();
        cyc(0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "sigloss");
        for (int i = 1; i <= 64; i++) cyc(0, 1'b1, 1'b1, vh(i), i == 64, 1'b0, "relock_sig");
    endtask

    task automatic test_40g();
        for (int i = 1; i <= 1024; i++) cyc(1, 1'b1, 1'b1, vh(i), i == 1024, 1'b0, "acq40");
        for (int i = 1; i <= 65; i++)
            cyc(1, 1'b1, 1'b1, 2'b11, i != 65, i == 65, "bad40");
        // Slip pulse is showing now; an async reset must kill it at once.
        rst40 = 1'b1;
        #1;
        total++;
        if ({if40.block_lock_o, if40.slip_v_o} !== 2'b00) begin
            bad++; $display("FAIL reset_in_slipwait got=%b exp=00", {if40.block_lock_o, if40.slip_v_o});
        end
        @(negedge clk);
        rst40 = 1'b0;
        cyc(1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, "count_after_reset");
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_slip_unlocked();
        test_locked_invalid();
        test_window_restart_and_gaps();
        test_signal_loss();
        test_40g();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
